// File: rtl/sck_rx.sv
// sck_rx: receiver for a slow external serial stream (sck/sdi/cs_n) into the
// clk domain. Words are DATA_W bits, MSB first, sampled on sck rising edges.
//
// Optional feature: define SCK_RX_TIMEOUT_EN to abandon a partial word after
// TIMEOUT clk cycles without an sck rise (frame stays open).
//
// Ports
//   clk      in   system clock, all logic on rising edge
//   rst      in   synchronous active-high reset
//   sck      in   external serial clock (async)
//   sdi      in   serial data, MSB first
//   cs_n     in   frame select, active-low (async)
//   rx_data  out  last complete word
//   rx_valid out  one-cycle pulse when rx_data updates
//   rx_abort out  one-cycle pulse when a partial word is discarded
//   rx_busy  out  high while a partial word is held
//
// state | meaning
// IDLE  | frame closed (cs_n high); counter and shift register held at 0
// SHIFT | frame open; sck rises shift sdi in
module sck_rx #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              sdi,
    input  logic              cs_n,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_abort,
    output logic              rx_busy
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    generate
        if (DATA_W < 2) begin : g_bad_width
            $error("sck_rx: DATA_W must be at least 2");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("sck_rx: TIMEOUT must be at least 1");
        end
    endgenerate

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic sck_s1, sck_s2, sck_s3;
    logic sdi_s1, sdi_s2;
    logic cs_s1, cs_s2;
    logic sck_rise;

    // Only DATA_W-1 bits are kept: the final bit goes straight into rx_data.
    logic [DATA_W-2:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] shifted;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_d;
    logic              valid_d, abort_d;

`ifdef SCK_RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    // Synchronizers reset to idle line levels so reset release never
    // fabricates an sck edge or an open frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_s1 <= 1'b0;
            sck_s2 <= 1'b0;
            sck_s3 <= 1'b0;
            sdi_s1 <= 1'b0;
            sdi_s2 <= 1'b0;
            cs_s1  <= 1'b1;
            cs_s2  <= 1'b1;
        end else begin
            sck_s1 <= sck;
            sck_s2 <= sck_s1;
            sck_s3 <= sck_s2;
            sdi_s1 <= sdi;
            sdi_s2 <= sdi_s1;
            cs_s1  <= cs_n;
            cs_s2  <= cs_s1;
        end
    end

    assign sck_rise = sck_s2 & ~sck_s3;
    assign shifted  = {shreg_q, sdi_s2};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = cs_s2 ? IDLE : SHIFT;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        data_d  = rx_data;
        valid_d = 1'b0;
        abort_d = 1'b0;
`ifdef SCK_RX_TIMEOUT_EN
        tmo_d   = TMO_LOAD;
`endif
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                shreg_d = '0;
            end
            SHIFT: begin
                // A bit arriving with the cs_n rise is still taken, so a
                // final bit completes its word before the frame closes.
                if (sck_rise) begin
                    if (cnt_q == LAST) begin
                        data_d  = shifted;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        shreg_d = '0;
                    end else begin
                        shreg_d = shifted[DATA_W-2:0];
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
`ifdef SCK_RX_TIMEOUT_EN
                else if (cnt_q != '0) begin
                    if (tmo_q == '0) begin
                        abort_d = 1'b1;
                        cnt_d   = '0;
                        shreg_d = '0;
                    end else begin
                        tmo_d = tmo_q - 1'b1;
                    end
                end
`endif
                if (state_d == IDLE && cnt_d != '0) begin
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end
            default: begin
                cnt_d   = '0;
                shreg_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            shreg_q  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_abort <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            rx_data  <= data_d;
            rx_valid <= valid_d;
            rx_abort <= abort_d;
        end
    end

`ifdef SCK_RX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign rx_busy = (cnt_q != '0);

endmodule

// File: tb/tb_sck_rx.sv
module tb_sck_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       sck;
    logic       sdi;
    logic       cs_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_abort;
    logic       rx_busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] obs_q[$];
    int         abort_cnt  = 0;
    int         valid_long = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] last_word  = 8'h00;

    sck_rx #(.DATA_W(8), .TIMEOUT(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .sck      (sck),
        .sdi      (sdi),
        .cs_n     (cs_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_abort (rx_abort),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    // Observer: records every delivered word and every abort pulse.
    always @(negedge clk) begin
        if (rx_valid) obs_q.push_back(rx_data);
        if (rx_abort) abort_cnt++;
        if (rx_valid && prev_valid) valid_long++;
        prev_valid = rx_valid;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] val, input int nbits,
                             input int hi, input int lo);
        for (int i = nbits - 1; i >= 0; i--) begin
            sdi = val[i];
            wait_cycles(lo);
            sck = 1'b1;
            wait_cycles(hi);
            sck = 1'b0;
        end
    endtask

    task automatic frame_open();
        cs_n = 1'b0;
        wait_cycles(4);
    endtask

    task automatic frame_close();
        wait_cycles(4);
        cs_n = 1'b1;
        wait_cycles(6);
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        cs_n = 1'b0;
        sck  = 1'b1;
        sdi  = 1'b1;
        wait_cycles(4);
        vectors++;
        if (rx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_data got=%h exp=00", rx_data);
        end
        vectors++;
        if (rx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid got=%b exp=0", rx_valid);
        end
        vectors++;
        if (rx_abort !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_abort got=%b exp=0", rx_abort);
        end
        vectors++;
        if (rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy got=%b exp=0", rx_busy);
        end
        sck  = 1'b0;
        sdi  = 1'b0;
        cs_n = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(4);
    endtask

    task automatic test_latency();
        int ab0;
        int lat;
        bit found;
        ab0 = abort_cnt;
        obs_q.delete();
        frame_open();
        send_bits(32'(8'hA5 >> 1), 7, 4, 5);
        sdi = 1'b1;
        wait_cycles(5);
        sck   = 1'b1;
        lat   = 0;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (rx_valid && !found) begin
                found = 1'b1;
                lat   = i;
            end
        end
        sck = 1'b0;
        vectors++;
        if (!found || lat != 3) begin
            miscompares++;
            $display("FAIL latency got=%0d found=%0b exp=3", lat, found);
        end
        vectors++;
        if (rx_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL latency_data got=%h exp=a5", rx_data);
        end
        frame_close();
        last_word = 8'hA5;
        vectors++;
        if (obs_q.size() != 1) begin
            miscompares++;
            $display("FAIL latency_count got=%0d exp=1", obs_q.size());
        end
        vectors++;
        if (valid_long != 0) begin
            miscompares++;
            $display("FAIL valid_width got=%0d long pulses exp=0", valid_long);
        end
        vectors++;
        if (abort_cnt != ab0) begin
            miscompares++;
            $display("FAIL latency_abort got=%0d exp=0", abort_cnt - ab0);
        end
    endtask

    task automatic test_back_to_back();
        int ab0;
        ab0 = abort_cnt;
        obs_q.delete();
        frame_open();
        send_bits(32'h3C, 8, 2, 2);
        send_bits(32'hC3, 8, 2, 2);
        frame_close();
        last_word = 8'hC3;
        vectors++;
        if (obs_q.size() != 2) begin
            miscompares++;
            $display("FAIL b2b_count got=%0d exp=2", obs_q.size());
        end else begin
            vectors++;
            if (obs_q[0] !== 8'h3C) begin
                miscompares++;
                $display("FAIL b2b_word0 got=%h exp=3c", obs_q[0]);
            end
            vectors++;
            if (obs_q[1] !== 8'hC3) begin
                miscompares++;
                $display("FAIL b2b_word1 got=%h exp=c3", obs_q[1]);
            end
        end
        vectors++;
        if (abort_cnt != ab0) begin
            miscompares++;
            $display("FAIL b2b_abort got=%0d exp=0", abort_cnt - ab0);
        end
    endtask

    task automatic test_abort();
        int ab0;
        ab0 = abort_cnt;
        obs_q.delete();
        frame_open();
        send_bits(32'h1F, 5, 3, 3);
        wait_cycles(5);
        vectors++;
        if (rx_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_busy_before got=%b exp=1", rx_busy);
        end
        cs_n = 1'b1;
        wait_cycles(6);
        vectors++;
        if (abort_cnt - ab0 != 1) begin
            miscompares++;
            $display("FAIL abort_pulse got=%0d exp=1", abort_cnt - ab0);
        end
        vectors++;
        if (rx_data !== last_word) begin
            miscompares++;
            $display("FAIL abort_data got=%h exp=%h", rx_data, last_word);
        end
        vectors++;
        if (rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_busy_after got=%b exp=0", rx_busy);
        end
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL abort_words got=%0d exp=0", obs_q.size());
        end
    endtask

    task automatic test_reset_mid_word();
        int ab0;
        ab0 = abort_cnt;
        frame_open();
        send_bits(32'hB, 4, 3, 3);
        wait_cycles(2);
        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        obs_q.delete();
        wait_cycles(4);
        send_bits(32'h5A, 8, 3, 3);
        frame_close();
        last_word = 8'h5A;
        vectors++;
        if (rx_data !== 8'h5A) begin
            miscompares++;
            $display("FAIL rstmid_data got=%h exp=5a", rx_data);
        end
        vectors++;
        if (obs_q.size() != 1) begin
            miscompares++;
            $display("FAIL rstmid_count got=%0d exp=1", obs_q.size());
        end
        vectors++;
        if (abort_cnt != ab0) begin
            miscompares++;
            $display("FAIL rstmid_abort got=%0d exp=0", abort_cnt - ab0);
        end
    endtask

    task automatic test_cs_same_cycle();
        int ab0;
        ab0 = abort_cnt;
        obs_q.delete();
        frame_open();
        send_bits(32'(8'h96 >> 1), 7, 3, 3);
        sdi = 1'b0;
        wait_cycles(3);
        sck  = 1'b1;
        cs_n = 1'b1;
        wait_cycles(3);
        sck = 1'b0;
        wait_cycles(8);
        last_word = 8'h96;
        vectors++;
        if (obs_q.size() != 1) begin
            miscompares++;
            $display("FAIL samecyc_count got=%0d exp=1", obs_q.size());
        end else begin
            vectors++;
            if (obs_q[0] !== 8'h96) begin
                miscompares++;
                $display("FAIL samecyc_data got=%h exp=96", obs_q[0]);
            end
        end
        vectors++;
        if (abort_cnt != ab0) begin
            miscompares++;
            $display("FAIL samecyc_abort got=%0d exp=0", abort_cnt - ab0);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 20; f++) begin
            logic [7:0] exp_q[$];
            logic [7:0] w;
            int nw, partial, hi, lo, ab0;
            logic [31:0] pbits;
            nw      = $urandom_range(0, 3);
            partial = $urandom_range(0, 7);
            hi      = $urandom_range(2, 5);
            lo      = $urandom_range(2, 5);
            pbits   = $urandom;
            ab0     = abort_cnt;
            obs_q.delete();
            frame_open();
            for (int k = 0; k < nw; k++) begin
                w = 8'($urandom);
                exp_q.push_back(w);
                send_bits(32'(w), 8, hi, lo);
            end
            if (partial > 0) send_bits(pbits, partial, hi, lo);
            frame_close();
            if (nw > 0) last_word = exp_q[nw-1];
            vectors++;
            if (obs_q.size() != exp_q.size()) begin
                miscompares++;
                $display("FAIL rand_count frame=%0d got=%0d exp=%0d",
                         f, obs_q.size(), exp_q.size());
            end else begin
                for (int k = 0; k < exp_q.size(); k++) begin
                    vectors++;
                    if (obs_q[k] !== exp_q[k]) begin
                        miscompares++;
                        $display("FAIL rand_word frame=%0d idx=%0d got=%h exp=%h",
                                 f, k, obs_q[k], exp_q[k]);
                    end
                end
            end
            vectors++;
            if (abort_cnt - ab0 != ((partial != 0) ? 1 : 0)) begin
                miscompares++;
                $display("FAIL rand_abort frame=%0d got=%0d exp=%0d",
                         f, abort_cnt - ab0, (partial != 0) ? 1 : 0);
            end
            vectors++;
            if (rx_data !== last_word) begin
                miscompares++;
                $display("FAIL rand_data frame=%0d got=%h exp=%h", f, rx_data, last_word);
            end
        end
        vectors++;
        if (valid_long != 0) begin
            miscompares++;
            $display("FAIL rand_valid_width got=%0d exp=0", valid_long);
        end
    endtask

`ifdef SCK_RX_TIMEOUT_EN
    task automatic test_timeout();
        int ab0;
        int when;
        ab0  = abort_cnt;
        when = -1;
        obs_q.delete();
        frame_open();
        send_bits(32'h5, 3, 2, 2);
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (rx_abort && when < 0) when = i;
        end
        vectors++;
        if (when < 60 || when > 72) begin
            miscompares++;
            $display("FAIL timeout_abort got_cycle=%0d exp=60..72", when);
        end
        vectors++;
        if (rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_busy got=%b exp=0", rx_busy);
        end
        send_bits(32'h81, 8, 2, 2);
        wait_cycles(6);
        vectors++;
        if (rx_data !== 8'h81) begin
            miscompares++;
            $display("FAIL timeout_next got=%h exp=81", rx_data);
        end
        frame_close();
        last_word = 8'h81;
        vectors++;
        if (abort_cnt - ab0 != 1) begin
            miscompares++;
            $display("FAIL timeout_abort_count got=%0d exp=1", abort_cnt - ab0);
        end
    endtask
`endif

    initial begin
        rst  = 1'b1;
        sck  = 1'b0;
        sdi  = 1'b0;
        cs_n = 1'b1;
        test_reset();
        test_latency();
        test_back_to_back();
        test_abort();
        test_reset_mid_word();
        test_cs_same_cycle();
        test_random();
`ifdef SCK_RX_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
